// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register: PC sequencing, delayed-branch
// redirect, exception flush, hazard stall and break-halt, feeding the ID stage.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          IMEM_AW   = 11,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  input  logic               flush_valid,
  input  logic [31:0]        flush_target,
  input  logic               halt_req,
  output logic [31:0]        pc,
  output logic [31:0]        instruction,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_p0;
  logic        vld_p1;
  logic [31:0] instr_p1, pc_p1, pc4_p1;
  logic [31:0] fetch_cnt;
  logic        pc_we, ifid_load, ifid_kill;
  logic [31:0] pc_d;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req && !flush_valid && !stall) state_d = HALTED;
      HALTED:  if (flush_valid) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Flush wins everywhere; otherwise only an unstalled RUN cycle moves the pipe.
  always_comb begin
    pc_we     = 1'b0;
    pc_d      = pc_p0;
    ifid_load = 1'b0;
    ifid_kill = 1'b0;
    halted    = (state_q == HALTED);
    if (flush_valid) begin
      pc_we     = 1'b1;
      pc_d      = word_align(flush_target);
      ifid_kill = 1'b1;
    end else if (state_q == RUN && !stall) begin
      if (halt_req) begin
        ifid_kill = 1'b1;
      end else begin
        pc_we     = 1'b1;
        ifid_load = 1'b1;
        pc_d      = redirect_valid ? word_align(redirect_target) : pc_p0 + 32'd4;
      end
    end
  end

  // p0: fetch PC
  always_ff @(posedge clk) begin
    if (!rst)       pc_p0 <= RESET_PC;
    else if (pc_we) pc_p0 <= pc_d;
  end

  assign imem_addr   = pc_p0[IMEM_AW+1:2];
  assign pc          = pc_p0;
  assign instruction = imem_rdata;

  // p1: IF/ID register; the current fetch is the delay slot on a redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      instr_p1  <= NOP_INSTR;
      pc_p1     <= 32'd0;
      pc4_p1    <= 32'd0;
      fetch_cnt <= 32'd0;
    end else if (ifid_kill) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
    end else if (ifid_load) begin
      vld_p1    <= 1'b1;
      instr_p1  <= imem_rdata;
      pc_p1     <= pc_p0;
      pc4_p1    <= pc_p0 + 32'd4;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign id_valid    = vld_p1;
  assign id_instr    = instr_p1;
  assign id_pc       = pc_p1;
  assign id_pc4      = pc4_p1;
  assign fetch_count = fetch_cnt;

endmodule
